// File: rtl/pio_pkg.sv
// Shared definitions for the parallel I/O register family
// (parallel_in_parallel_out, parallel_in_serial_out, serial_in_parallel_out).
package pio_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // Default word width shared by the whole family.
    localparam int PIO_WIDTH = 4;

    // Bit counter width for a given word width.
    function automatic int cnt_w(input int width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/parallel_in_serial_out.sv
// Serializer: accepts a WIDTH-bit word over valid/ready and shifts it out one
// bit per clock, with frame_start on the first bit and last on the final bit.
module parallel_in_serial_out
    import pio_pkg::*;
#(
    parameter int WIDTH     = PIO_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             frame_start,
    output logic             last
);

    localparam int            CW       = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] shift_reg, shift_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             sout_next, sout_valid_next, frame_start_next, last_next;
    logic             transfer;
    logic [WIDTH-1:0] shifted;

    // Bit that sits at the output end of the shift register.
    function automatic logic out_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Ready while idle or while the final bit of the current word is on the line,
    // which is what allows gapless back-to-back words.
    assign din_ready = (state_reg == IDLE) || (cnt_reg == LAST_CNT);
    assign transfer  = din_valid && din_ready;
    assign shifted   = MSB_FIRST ? (shift_reg << 1) : (shift_reg >> 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            cnt_reg     <= '0;
            sout        <= 1'b0;
            sout_valid  <= 1'b0;
            frame_start <= 1'b0;
            last        <= 1'b0;
        end else begin
            state_reg   <= state_next;
            shift_reg   <= shift_next;
            cnt_reg     <= cnt_next;
            sout        <= sout_next;
            sout_valid  <= sout_valid_next;
            frame_start <= frame_start_next;
            last        <= last_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        shift_next       = shift_reg;
        cnt_next         = cnt_reg;
        sout_next        = 1'b0;
        sout_valid_next  = 1'b0;
        frame_start_next = 1'b0;
        last_next        = 1'b0;

        if (transfer) begin
            // A new word always starts with the frame marker, whether from IDLE
            // or directly after the previous word's last bit.
            state_next       = SHIFT;
            shift_next       = din;
            cnt_next         = '0;
            sout_next        = out_bit(din);
            sout_valid_next  = 1'b1;
            frame_start_next = 1'b1;
            last_next        = (WIDTH == 1);
        end else begin
            unique case (state_reg)
                IDLE: begin
                    cnt_next = '0;
                end
                SHIFT: begin
                    if (cnt_reg == LAST_CNT) begin
                        state_next = IDLE;
                        cnt_next   = '0;
                    end else begin
                        shift_next      = shifted;
                        cnt_next        = cnt_reg + CW'(1);
                        sout_next       = out_bit(shifted);
                        sout_valid_next = 1'b1;
                        last_next       = ((cnt_reg + CW'(1)) == LAST_CNT);
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_parallel_in_serial_out.sv
// Bench: MSB-first and LSB-first serializers driven in parallel, checked against
// a word/bit-position model every cycle plus hand-computed sequences.
module tb_parallel_in_serial_out;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] din = '0;
    logic         din_valid = 1'b0;

    logic ready_m, sout_m, valid_m, frame_m, last_m;
    logic ready_l, sout_l, valid_l, frame_l, last_l;

    int checks = 0;
    int errors = 0;

    parallel_in_serial_out #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(ready_m), .sout(sout_m), .sout_valid(valid_m),
        .frame_start(frame_m), .last(last_m)
    );

    parallel_in_serial_out #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(ready_l), .sout(sout_l), .sout_valid(valid_l),
        .frame_start(frame_l), .last(last_l)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: the word being sent and the index of the bit currently on the line.
    logic         m_active = 1'b0;
    int           m_pos = 0;
    logic [W-1:0] m_word = '0;
    logic         m_ready;
    logic         m_bit_msb, m_bit_lsb, m_frame, m_last;

    assign m_ready   = !m_active || (m_pos == W - 1);
    assign m_frame   = m_active && (m_pos == 0);
    assign m_last    = m_active && (m_pos == W - 1);
    assign m_bit_msb = m_active ? m_word[W-1-m_pos] : 1'b0;
    assign m_bit_lsb = m_active ? m_word[m_pos] : 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active <= 1'b0;
            m_pos    <= 0;
            m_word   <= '0;
        end else if (din_valid && m_ready) begin
            m_active <= 1'b1;
            m_pos    <= 0;
            m_word   <= din;
        end else if (m_active && m_pos != W - 1) begin
            m_pos <= m_pos + 1;
        end else begin
            m_active <= 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("m.sout",   {7'b0, sout_m},  {7'b0, m_bit_msb});
        chk("m.valid",  {7'b0, valid_m}, {7'b0, m_active});
        chk("m.frame",  {7'b0, frame_m}, {7'b0, m_frame});
        chk("m.last",   {7'b0, last_m},  {7'b0, m_last});
        chk("m.ready",  {7'b0, ready_m}, {7'b0, m_ready});
        chk("l.sout",   {7'b0, sout_l},  {7'b0, m_bit_lsb});
        chk("l.valid",  {7'b0, valid_l}, {7'b0, m_active});
        chk("l.frame",  {7'b0, frame_l}, {7'b0, m_frame});
        chk("l.last",   {7'b0, last_l},  {7'b0, m_last});
        chk("l.ready",  {7'b0, ready_l}, {7'b0, m_ready});
    end

    // Offer one word for a single cycle from IDLE; returns 1ns after the acceptance edge.
    task automatic send_one(input logic [W-1:0] word);
        @(posedge clk); #1;
        din = word; din_valid = 1'b1;
        @(posedge clk); #1;
        din_valid = 1'b0; din = W'($urandom);
    endtask

    logic [7:0] pat;
    logic [3:0] pl;

    initial begin
        // Reset held from time zero.
        #2;
        chk("rst.valid", {7'b0, valid_m}, 8'd0);
        chk("rst.sout",  {7'b0, sout_m},  8'd0);
        chk("rst.ready", {7'b0, ready_m}, 8'd1);
        @(posedge clk); #3 rst = 1'b0;
        repeat (2) @(posedge clk);

        // Single word 1010: MSB 1,0,1,0; LSB 0,1,0,1.
        send_one(4'b1010);
        pat = 8'b0000_1010; pl = 4'b0101;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("single.sout_m", {7'b0, sout_m}, {7'b0, pat[4-c]});
            chk("single.sout_l", {7'b0, sout_l}, {7'b0, pl[4-c]});
            chk("single.valid", {7'b0, valid_m}, 8'd1);
            chk("single.frame", {7'b0, frame_m}, {7'b0, c == 1});
            chk("single.last",  {7'b0, last_m},  {7'b0, c == 4});
        end
        @(negedge clk);
        chk("single.idle", {7'b0, valid_m}, 8'd0);

        // LSB-first 0011 -> 1,1,0,0.
        send_one(4'b0011);
        pl = 4'b1100;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("lsb.sout", {7'b0, sout_l}, {7'b0, pl[4-c]});
        end

        // Back-to-back 1100 then 0101 with valid held high.
        repeat (2) @(posedge clk);
        #1 din = 4'b1100; din_valid = 1'b1;
        @(posedge clk); #1 din = 4'b0101;
        pat = 8'b1100_0101;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 5) din_valid = 1'b0;
            chk("b2b.sout",  {7'b0, sout_m},  {7'b0, pat[8-c]});
            chk("b2b.valid", {7'b0, valid_m}, 8'd1);
            chk("b2b.frame", {7'b0, frame_m}, {7'b0, c == 1 || c == 5});
            chk("b2b.ready", {7'b0, ready_m}, {7'b0, c == 4 || c == 8});
        end
        @(negedge clk);
        chk("b2b.idle", {7'b0, valid_m}, 8'd0);

        // Hold-off: 1111 offered at bit 2 of 0110, changed to 1011 while held.
        send_one(4'b0110);
        pat = 8'b0110_1011;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 2) begin din = 4'b1111; din_valid = 1'b1; end
            if (c == 3) din = 4'b1011;
            if (c == 5) begin din_valid = 1'b0; din = 4'b0000; end
            chk("hold.sout",  {7'b0, sout_m},  {7'b0, pat[8-c]});
            chk("hold.frame", {7'b0, frame_m}, {7'b0, c == 1 || c == 5});
        end

        // Reset mid-word after 2 of 4 bits of 1001.
        send_one(4'b1001);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst.valid", {7'b0, valid_m}, 8'd0);
        chk("midrst.sout",  {7'b0, sout_m},  8'd0);
        chk("midrst.frame", {7'b0, frame_m}, 8'd0);
        chk("midrst.last",  {7'b0, last_m},  8'd0);
        chk("midrst.ready", {7'b0, ready_m}, 8'd1);
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("midrst.quiet", {7'b0, valid_m}, 8'd0);
        end
        send_one(4'b0110);
        pat = 8'b0000_0110;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            chk("after.sout",  {7'b0, sout_m},  {7'b0, pat[4-c]});
            chk("after.valid", {7'b0, valid_m}, 8'd1);
        end

        // Random traffic with occasional mid-cycle resets.
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            din       = W'($urandom);
            din_valid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 149) == 0) begin
                #3 rst = 1'b1;
                @(posedge clk); #3 rst = 1'b0;
            end
        end
        din_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
